// File: rtl/shift_unit_pipelined_if.sv
// shift_unit_pipelined_if: operand and result handshake bundle for shift_unit_pipelined
//   master: operand source / result consumer side
//   slave : the shift unit
//   in_*  : operand beat (data, amount, op) with valid/ready
//   out_* : result beat (data, carry, zero, err) with valid/ready
interface shift_unit_pipelined_if #(parameter int WIDTH = 8);
  localparam int AMT_W = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;
  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );
  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );
endinterface

// File: rtl/shift_unit_pipelined.sv
// shift_unit_pipelined: two-stage pipelined shift/rotate unit with valid/ready handshakes
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, discards in-flight beats
//   bus   : shift_unit_pipelined_if.slave (operand in, result out)
//   ops   : 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   SHIFT_ROTATE_EN : when defined, ROL/ROR are built; otherwise they report err
module shift_unit_pipelined #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  shift_unit_pipelined_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH);
  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;
  logic [AMT_W-1:0] s0_amt;
  logic [2:0]       s0_op;
  logic             s1_free;
  logic             accept;
  logic [WIDTH:0]   sll_w;
  logic [WIDTH:0]   sr_w;
  logic [WIDTH:0]   sra_w;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             legal;
  assign s1_free      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !reset && (!s0_valid || s1_free);
  assign accept       = bus.in_valid && bus.in_ready;
  // One guard bit on the side the data leaves catches the last bit shifted out;
  // it is naturally 0 when the amount is 0.
  assign sll_w = {1'b0, s0_data} << s0_amt;
  assign sr_w  = {s0_data, 1'b0} >> s0_amt;
  assign sra_w = $signed({s0_data, 1'b0}) >>> s0_amt;
`ifdef SHIFT_ROTATE_EN
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  // A shift by WIDTH yields 0, so amount 0 reduces to y = a.
  assign rol = (s0_data << s0_amt) | (s0_data >> (WIDTH - s0_amt));
  assign ror = (s0_data >> s0_amt) | (s0_data << (WIDTH - s0_amt));
`endif
  always_comb begin
    y     = s0_data;
    carry = 1'b0;
    legal = 1'b1;
    if (s0_op == 3'd0) {carry, y} = sll_w;
    else if (s0_op == 3'd1) {y, carry} = sr_w;
    else if (s0_op == 3'd2) {y, carry} = sra_w;
`ifdef SHIFT_ROTATE_EN
    else if (s0_op == 3'd3) begin
      y     = rol;
      carry = (s0_amt != '0) && rol[0];
    end
    else if (s0_op == 3'd4) begin
      y     = ror;
      carry = (s0_amt != '0) && ror[WIDTH-1];
    end
`endif
    else legal = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_carry <= 1'b0;
      bus.out_zero  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      if (s1_free) bus.out_valid <= s0_valid;
      if (s1_free && s0_valid) begin
        bus.out_data  <= y;
        bus.out_carry <= carry;
        bus.out_zero  <= (y == '0);
        bus.out_err   <= !legal;
      end
      if (accept) begin
        s0_valid <= 1'b1;
        s0_data  <= bus.in_data;
        s0_amt   <= bus.in_amt;
        s0_op    <= bus.in_op;
      end else if (s1_free) s0_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_unit_pipelined.sv
// tb_shift_unit_pipelined: directed and streaming checks of shift_unit_pipelined at WIDTH 8
module tb_shift_unit_pipelined;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  shift_unit_pipelined_if #(.WIDTH(8)) bus ();
  shift_unit_pipelined #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // Bit-serial reference: one single-bit step per unit of amount.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [2:0] n, input logic [2:0] op);
    logic [7:0] y;
    logic c;
    logic ok;
    y = a;
    c = 1'b0;
`ifdef SHIFT_ROTATE_EN
    ok = op <= 3'd4;
`else
    ok = op <= 3'd2;
`endif
    if (ok)
      for (int i = 0; i < int'(n); i++) begin
        if (op == 3'd0) begin c = y[7]; y = {y[6:0], 1'b0}; end
        else if (op == 3'd1) begin c = y[0]; y = {1'b0, y[7:1]}; end
        else if (op == 3'd2) begin c = y[0]; y = {y[7], y[7:1]}; end
        else if (op == 3'd3) begin y = {y[6:0], y[7]}; c = y[0]; end
        else begin y = {y[0], y[7:1]}; c = y[7]; end
      end
    return {!ok, y == 8'h00, c, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    bus.in_amt = '0;
    bus.in_op = '0;
    tick();
    tick();
    tests++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    tests++;
    if ({bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%b z=%b e=%b expected all 0",
               bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_err);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic do_one(input string nm, input logic [7:0] a, input logic [2:0] n, input logic [2:0] op,
                        input logic [7:0] ey, input logic ec, input logic ez, input logic ee);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = a;
    bus.in_amt = n;
    bus.in_op = op;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL %s_accept: in_ready got %b expected 1", nm, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s_early: out_valid got %b expected 0", nm, bus.out_valid); end
    tick();
    tests++;
    if ({bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== {1'b1, ey, ec, ez, ee}) begin
      fails++;
      $display("FAIL %s: got v=%b y=%h c=%b z=%b e=%b expected v=1 y=%h c=%b z=%b e=%b", nm,
               bus.out_valid, bus.out_data, bus.out_carry, bus.out_zero, bus.out_err, ey, ec, ez, ee);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s_drain: out_valid got %b expected 0", nm, bus.out_valid); end
  endtask

  task automatic test_ops();
    do_one("sll_b5_3", 8'hB5, 3'd3, 3'b000, 8'hA8, 1'b1, 1'b0, 1'b0);
    do_one("sra_96_2", 8'h96, 3'd2, 3'b010, 8'hE5, 1'b1, 1'b0, 1'b0);
    do_one("srl_01_1", 8'h01, 3'd1, 3'b001, 8'h00, 1'b1, 1'b1, 1'b0);
    do_one("sll_n0", 8'hFF, 3'd0, 3'b000, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_one("sll_03_7", 8'h03, 3'd7, 3'b000, 8'h80, 1'b1, 1'b0, 1'b0);
    do_one("sra_80_7", 8'h80, 3'd7, 3'b010, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_one("srl_80_7", 8'h80, 3'd7, 3'b001, 8'h01, 1'b0, 1'b0, 1'b0);
    do_one("illegal_110", 8'h3C, 3'd2, 3'b110, 8'h3C, 1'b0, 1'b0, 1'b1);
`ifdef SHIFT_ROTATE_EN
    do_one("rol_81_1", 8'h81, 3'd1, 3'b011, 8'h03, 1'b1, 1'b0, 1'b0);
    do_one("ror_01_1", 8'h01, 3'd1, 3'b100, 8'h80, 1'b1, 1'b0, 1'b0);
    do_one("rol_n0", 8'h81, 3'd0, 3'b011, 8'h81, 1'b0, 1'b0, 1'b0);
`else
    do_one("rol_off", 8'h81, 3'd1, 3'b011, 8'h81, 1'b0, 1'b0, 1'b1);
    do_one("ror_off", 8'h01, 3'd1, 3'b100, 8'h01, 1'b0, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_back_to_back();
    logic [10:0] q[$];
    logic [10:0] ev;
    int got = 0;
    int first = -1;
    bit ir_ok = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      bus.in_valid = cyc < 16;
      bus.in_data = 8'($urandom);
      bus.in_amt = 3'($urandom);
      bus.in_op = 3'($urandom_range(0, 7));
      #1;
      if (cyc < 16 && bus.in_ready !== 1'b1) ir_ok = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL stream_spurious: result at cycle %0d with none expected", cyc); end
        else begin
          ev = q.pop_front();
          if ({bus.out_err, bus.out_zero, bus.out_carry, bus.out_data} !== ev || cyc != first + got) begin
            fails++;
            $display("FAIL stream_beat%0d: got e/z/c/y=%h at cycle %0d expected %h at cycle %0d", got,
                     {bus.out_err, bus.out_zero, bus.out_carry, bus.out_data}, cyc, ev, first + got);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_data, bus.in_amt, bus.in_op));
      tick();
    end
    bus.in_valid = 1'b0;
    tests++;
    if (got != 16 || !ir_ok) begin fails++; $display("FAIL stream_count: got %0d results in_ready_ok=%b expected 16 and 1", got, ir_ok); end
  endtask

  task automatic test_backpressure();
    logic [10:0] q[$];
    logic [10:0] ev;
    logic [7:0] held;
    int got = 0;
    int sent = 0;
    int blocked = 0;
    bit was_stalled = 1'b0;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 10; cyc++) begin
      if (!bus.in_valid && sent < 10) begin
        bus.in_data = 8'($urandom);
        bus.in_amt = 3'($urandom);
        bus.in_op = 3'($urandom_range(0, 4));
      end
      bus.in_valid = sent < 10;
      bus.out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      if (was_stalled) begin
        tests++;
        if (bus.out_data !== held) begin fails++; $display("FAIL bp_stable: out_data got %h expected %h", bus.out_data, held); end
      end
      if (!bus.in_ready) begin
        blocked++;
        tests++;
        if (!(bus.out_valid && !bus.out_ready)) begin
          fails++;
          $display("FAIL bp_ready_cause: in_ready 0 with out_valid=%b out_ready=%b expected 1 and 0", bus.out_valid, bus.out_ready);
        end
      end
      was_stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        ev = q.size() != 0 ? q.pop_front() : 11'h7FF;
        if ({bus.out_err, bus.out_zero, bus.out_carry, bus.out_data} !== ev) begin
          fails++;
          $display("FAIL bp_beat%0d: got e/z/c/y=%h expected %h", got, {bus.out_err, bus.out_zero, bus.out_carry, bus.out_data}, ev);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_data, bus.in_amt, bus.in_op));
        sent++;
        tick();
        bus.in_valid = 1'b0;
      end else tick();
    end
    bus.in_valid = 1'b0;
    tests++;
    if (got != 10 || q.size() != 0 || blocked == 0) begin
      fails++;
      $display("FAIL bp_count: got %0d results left %0d blocked %0d expected 10, 0, nonzero", got, q.size(), blocked);
    end
  endtask

  task automatic test_reset_flight();
    bit seen = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h11;
    bus.in_amt = 3'd1;
    bus.in_op = 3'd0;
    tick();
    bus.in_data = 8'h22;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rst_fill: out_valid got %b expected 1", bus.out_valid); end
    reset = 1'b1;
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_flush: out_valid=%b in_ready=%b expected 0 0", bus.out_valid, bus.in_ready);
    end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL rst_ghost: out_valid got 1 expected 0 after reset"); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
